// File: rtl/alu_shift_seq_pkg.sv
// Shared encodings for the multi-step shift/rotate sequencer: request kinds,
// the one-bit ALU op codes, FSM states and the ALU flag-bit indices.
`ifndef CIDX
`define CIDX 0
`endif
`ifndef ZIDX
`define ZIDX 1
`endif
`ifndef SIDX
`define SIDX 2
`endif
`ifndef VIDX
`define VIDX 3
`endif

package alu_shift_seq_pkg;

    typedef enum logic [2:0] {
        KIND_SHL = 3'd0,
        KIND_SHR = 3'd1,
        KIND_SHA = 3'd2,
        KIND_ROR = 3'd3,
        KIND_ROL = 3'd4
    } kind_e;

    localparam logic [5:0] ALU_OP_NONE = 6'h00;
    localparam logic [5:0] ALU_OP_ROR  = 6'h26;
    localparam logic [5:0] ALU_OP_ROL  = 6'h27;
    localparam logic [5:0] ALU_OP_SHL  = 6'h28;
    localparam logic [5:0] ALU_OP_SHR  = 6'h29;
    localparam logic [5:0] ALU_OP_SHA  = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Illegal kinds map to ALU_OP_NONE, which doubles as the legality test.
    function automatic logic [5:0] kind_to_op(input logic [2:0] kind);
        logic [5:0] op;
        case (kind)
            KIND_SHL: op = ALU_OP_SHL;
            KIND_SHR: op = ALU_OP_SHR;
            KIND_SHA: op = ALU_OP_SHA;
            KIND_ROR: op = ALU_OP_ROR;
            KIND_ROL: op = ALU_OP_ROL;
            default:  op = ALU_OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic kind_is_legal(input logic [2:0] kind);
        return (kind_to_op(kind) != ALU_OP_NONE);
    endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Shift/rotate sequencer: turns one "shift by N" request into N single-bit
// ALU ops, feeding result and flags back each step. Option: ALU_SEQ_ABORT_EN.
module alu_shift_seq
    import alu_shift_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CWIDTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [CWIDTH-1:0] req_cnt,
    input  logic [WIDTH-1:0]  req_di,
    input  logic [WIDTH-1:0]  req_fi,
    output logic [5:0]        alu_op,
    output logic [WIDTH-1:0]  alu_di,
    output logic [WIDTH-1:0]  alu_fi,
    input  logic [WIDTH-1:0]  alu_res,
    input  logic [WIDTH-1:0]  alu_fo,
    output logic              busy,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [WIDTH-1:0]  res,
    output logic [WIDTH-1:0]  fo,
    output logic              err
`ifdef ALU_SEQ_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [CWIDTH-1:0] CNT_ZERO = {CWIDTH{1'b0}};
    localparam logic [CWIDTH-1:0] CNT_ONE  = {{(CWIDTH-1){1'b0}}, 1'b1};

    state_e              state_r, state_s;
    logic [WIDTH-1:0]    wd_r, wd_s;
    logic [WIDTH-1:0]    wf_r, wf_s;
    logic [CWIDTH-1:0]   cnt_r, cnt_s;
    logic [5:0]          op_r, op_s;
    logic [WIDTH-1:0]    res_r, res_s;
    logic [WIDTH-1:0]    fo_r, fo_s;
    logic                err_r, err_s;
    logic                done_valid_r, done_valid_s;
    logic                req_ready_r, req_ready_s;
    logic                busy_r, busy_s;
    logic                abort_s;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state and next-register values for the sequencer FSM
    always_comb begin
        state_s      = state_r;
        wd_s         = wd_r;
        wf_s         = wf_r;
        cnt_s        = cnt_r;
        op_s         = op_r;
        res_s        = res_r;
        fo_s         = fo_r;
        err_s        = err_r;
        done_valid_s = done_valid_r;
        req_ready_s  = req_ready_r;
        busy_s       = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    wd_s        = req_di;
                    wf_s        = req_fi;
                    cnt_s       = req_cnt;
                    req_ready_s = 1'b0;
                    busy_s      = 1'b1;
                    if (!kind_is_legal(req_kind)) begin
                        state_s      = ST_DONE;
                        res_s        = req_di;
                        fo_s         = req_fi;
                        err_s        = 1'b1;
                        done_valid_s = 1'b1;
                    end else if (req_cnt == CNT_ZERO) begin
                        state_s      = ST_DONE;
                        res_s        = req_di;
                        fo_s         = req_fi;
                        err_s        = 1'b0;
                        done_valid_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        op_s    = kind_to_op(req_kind);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort wins over the final step and reports the pre-step word.
                if (abort_s) begin
                    state_s      = ST_DONE;
                    op_s         = ALU_OP_NONE;
                    res_s        = wd_r;
                    fo_s         = wf_r;
                    err_s        = 1'b1;
                    done_valid_s = 1'b1;
                end else begin
                    wd_s  = alu_res;
                    wf_s  = alu_fo;
                    cnt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_s      = ST_DONE;
                        op_s         = ALU_OP_NONE;
                        res_s        = alu_res;
                        fo_s         = alu_fo;
                        err_s        = 1'b0;
                        done_valid_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_s      = ST_IDLE;
                    done_valid_s = 1'b0;
                    req_ready_s  = 1'b1;
                    busy_s       = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                op_s         = ALU_OP_NONE;
                done_valid_s = 1'b0;
                req_ready_s  = 1'b1;
                busy_s       = 1'b0;
            end
        endcase
    end

    // State, working and output registers; reset aborts any operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            wd_r         <= {WIDTH{1'b0}};
            wf_r         <= {WIDTH{1'b0}};
            cnt_r        <= CNT_ZERO;
            op_r         <= ALU_OP_NONE;
            res_r        <= {WIDTH{1'b0}};
            fo_r         <= {WIDTH{1'b0}};
            err_r        <= 1'b0;
            done_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            wd_r         <= wd_s;
            wf_r         <= wf_s;
            cnt_r        <= cnt_s;
            op_r         <= op_s;
            res_r        <= res_s;
            fo_r         <= fo_s;
            err_r        <= err_s;
            done_valid_r <= done_valid_s;
            req_ready_r  <= req_ready_s;
            busy_r       <= busy_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign alu_op     = op_r;
    assign alu_di     = wd_r;
    assign alu_fi     = wf_r;
    assign busy       = busy_r;
    assign done_valid = done_valid_r;
    assign res        = res_r;
    assign fo         = fo_r;
    assign err        = err_r;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq with a behavioural one-bit ALU on the
// alu_* ports and a whole-shift reference model; covers ALU_SEQ_ABORT_EN when defined.
`ifndef CIDX
`define CIDX 0
`endif
`ifndef ZIDX
`define ZIDX 1
`endif
`ifndef SIDX
`define SIDX 2
`endif

module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  req_cnt;
    logic [31:0] req_di, req_fi;
    logic [5:0]  alu_op;
    logic [31:0] alu_di, alu_fi, alu_res, alu_fo;
    logic        busy, done_valid, done_ready;
    logic [31:0] res, fo;
    logic        err;
`ifdef ALU_SEQ_ABORT_EN
    logic        abort;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    int          got_lat, got_runs, got_badop;
    logic [31:0] got_res, got_fo;
    logic        got_err, got_to;

    always #5 clk = ~clk;

    alu_shift_seq #(.WIDTH(32), .CWIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_cnt(req_cnt), .req_di(req_di), .req_fi(req_fi),
        .alu_op(alu_op), .alu_di(alu_di), .alu_fi(alu_fi),
        .alu_res(alu_res), .alu_fo(alu_fo),
        .busy(busy), .done_valid(done_valid), .done_ready(done_ready),
        .res(res), .fo(fo), .err(err)
`ifdef ALU_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    // Stand-in for the CPU2 ALU: one-bit shift/rotate with C, Z, S update
    logic alu_c;
    always_comb begin
        alu_res = alu_di;
        alu_fo  = alu_fi;
        alu_c   = alu_fi[`CIDX];
        case (alu_op)
            6'h28: begin alu_res = {alu_di[30:0], 1'b0};          alu_c = alu_di[31]; end
            6'h29: begin alu_res = {1'b0, alu_di[31:1]};          alu_c = alu_di[0];  end
            6'h2A: begin alu_res = {alu_di[31], alu_di[31:1]};    alu_c = alu_di[0];  end
            6'h26: begin alu_res = {alu_fi[`CIDX], alu_di[31:1]}; alu_c = alu_di[0];  end
            6'h27: begin alu_res = {alu_di[30:0], alu_fi[`CIDX]}; alu_c = alu_di[31]; end
            default: ;
        endcase
        if (alu_op != 6'h00) begin
            alu_fo[`CIDX] = alu_c;
            alu_fo[`ZIDX] = (alu_res == 32'h0);
            alu_fo[`SIDX] = alu_res[31];
        end
    end

    function automatic logic [5:0] want_op(input logic [2:0] k);
        logic [5:0] tbl [0:4];
        tbl[0] = 6'h28; tbl[1] = 6'h29; tbl[2] = 6'h2A; tbl[3] = 6'h26; tbl[4] = 6'h27;
        return (k <= 3'd4) ? tbl[k] : 6'h00;
    endfunction

    // Whole-request reference: shift by n at once, rotates through a 33-bit {C,data} ring.
    function automatic void ref_shift(input logic [2:0] k, input int n, input logic [31:0] d,
                                      input logic [31:0] f, output logic [31:0] r,
                                      output logic [31:0] fe, output logic e);
        logic [63:0] w;
        logic [65:0] ring;
        logic        c;
        r = d; fe = f; e = 1'b0; c = f[`CIDX];
        if (k > 3'd4) begin e = 1'b1; return; end
        if (n == 0) return;
        case (k)
            3'd0: begin w = {32'h0, d} << n; r = w[31:0];  c = w[32]; end
            3'd1: begin w = {d, 32'h0} >> n; r = w[63:32]; c = w[31]; end
            3'd2: begin w = $signed({d, 32'h0}) >>> n; r = w[63:32]; c = w[31]; end
            3'd3: begin ring = {c, d, c, d} >> (n % 33); r = ring[31:0];  c = ring[32]; end
            default: begin ring = {c, d, c, d} << (n % 33); r = ring[64:33]; c = ring[65]; end
        endcase
        fe[`CIDX] = c;
        fe[`ZIDX] = (r == 32'h0);
        fe[`SIDX] = r[31];
    endfunction

    task automatic send_req(input logic [2:0] k, input logic [4:0] n,
                            input logic [31:0] d, input logic [31:0] f);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_kind = k; req_cnt = n; req_di = d; req_fi = f; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got_lat = 0; got_runs = 0; got_badop = 0;
        do begin
            @(negedge clk);
            got_lat++;
            if (alu_op != 6'h00) begin
                got_runs++;
                if (alu_op !== want_op(k)) got_badop++;
            end
        end while (!done_valid && got_lat < 100);
        got_to = !done_valid; got_res = res; got_fo = fo; got_err = err;
    endtask

    task automatic take_result(input int hold);
        repeat (hold) @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1 done_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || err !== 1'b0) begin
            n_mis++; $display("FAIL reset_ctrl: ready=%b busy=%b dv=%b err=%b, want 1 0 0 0", req_ready, busy, done_valid, err); end
        n_cmp++; if (alu_op !== 6'h00 || alu_di !== 32'h0 || alu_fi !== 32'h0 || res !== 32'h0 || fo !== 32'h0) begin
            n_mis++; $display("FAIL reset_data: op=%h di=%h fi=%h res=%h fo=%h, want all 0", alu_op, alu_di, alu_fi, res, fo); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] r1, f1;
        send_req(3'd0, 5'd4, 32'h8000_0001, 32'h0);
        n_cmp++; if (got_runs !== 4 || got_lat !== 5 || got_badop !== 0) begin
            n_mis++; $display("FAIL shl_timing: runs=%0d lat=%0d badop=%0d, want 4 5 0", got_runs, got_lat, got_badop); end
        n_cmp++; if (got_res !== 32'h0000_0010 || got_fo !== 32'h0 || got_err !== 1'b0) begin
            n_mis++; $display("FAIL shl_result: res=%h fo=%h err=%b, want 00000010 0 0", got_res, got_fo, got_err); end
        take_result(0);

        send_req(3'd2, 5'd31, 32'h8000_0000, 32'h0);
        n_cmp++; if (got_lat !== 32 || got_runs !== 31) begin
            n_mis++; $display("FAIL sha_latency: lat=%0d runs=%0d, want 32 31", got_lat, got_runs); end
        n_cmp++; if (got_res !== 32'hFFFF_FFFF || got_fo[`SIDX] !== 1'b1 || got_fo[`CIDX] !== 1'b0) begin
            n_mis++; $display("FAIL sha_result: res=%h fo=%h, want ffffffff S=1 C=0", got_res, got_fo); end
        take_result(1);

        // Full 33-step rotation through carry, split as 31 + 2 since cnt tops out at 31.
        send_req(3'd3, 5'd31, 32'h1234_5678, 32'h1 << `CIDX);
        r1 = got_res; f1 = got_fo;
        take_result(0);
        send_req(3'd3, 5'd2, r1, f1);
        n_cmp++; if (got_res !== 32'h1234_5678 || got_fo !== (32'h1 << `CIDX)) begin
            n_mis++; $display("FAIL ror_full_turn: res=%h fo=%h, want 12345678 %h", got_res, got_fo, 32'h1 << `CIDX); end
        take_result(0);
    endtask

    task automatic test_zero_hold();
        send_req(3'd1, 5'd0, 32'hDEAD_BEEF, 32'h5);
        n_cmp++; if (got_lat !== 1 || got_res !== 32'hDEAD_BEEF || got_fo !== 32'h5 || got_err !== 1'b0) begin
            n_mis++; $display("FAIL zero_cnt: lat=%0d res=%h fo=%h err=%b, want 1 deadbeef 5 0", got_lat, got_res, got_fo, got_err); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (done_valid !== 1'b1 || res !== 32'hDEAD_BEEF || fo !== 32'h5 || req_ready !== 1'b0) begin
                n_mis++; $display("FAIL done_hold%0d: dv=%b res=%h fo=%h ready=%b, want 1 deadbeef 5 0", i, done_valid, res, fo, req_ready); end
        end
        take_result(0);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0) begin
            n_mis++; $display("FAIL handoff: ready=%b dv=%b busy=%b, want 1 0 0", req_ready, done_valid, busy); end
    endtask

    task automatic test_illegal();
        int guard;
        send_req(3'd6, 5'd7, 32'hA5A5_0F0F, 32'h3);
        n_cmp++; if (got_lat !== 1 || got_err !== 1'b1 || got_res !== 32'hA5A5_0F0F || got_fo !== 32'h3 || got_runs !== 0) begin
            n_mis++; $display("FAIL illegal_kind: lat=%0d err=%b res=%h fo=%h runs=%0d, want 1 1 a5a50f0f 3 0", got_lat, got_err, got_res, got_fo, got_runs); end
        req_kind = 3'd0; req_cnt = 5'd2; req_di = 32'h1; req_fi = 32'h0; req_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (done_valid !== 1'b1 || res !== 32'hA5A5_0F0F || err !== 1'b1 || busy !== 1'b1) begin
            n_mis++; $display("FAIL req_in_done: dv=%b res=%h err=%b busy=%b, want 1 a5a50f0f 1 1", done_valid, res, err, busy); end
        take_result(0);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            n_mis++; $display("FAIL no_accept_at_handoff: busy=%b ready=%b, want 0 1", busy, req_ready); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!done_valid && guard < 50);
        n_cmp++; if (done_valid !== 1'b1 || guard !== 3 || res !== 32'h4 || err !== 1'b0) begin
            n_mis++; $display("FAIL accept_after_handoff: dv=%b lat=%0d res=%h err=%b, want 1 3 4 0", done_valid, guard, res, err); end
        take_result(0);
    endtask

    task automatic test_random();
        logic [2:0]  k;
        logic [4:0]  n;
        logic [31:0] d, f, er, ef;
        logic        ee;
        int          elat, eruns;
        for (int t = 0; t < 24; t++) begin
            k = 3'($urandom_range(0, 7));
            n = 5'($urandom_range(0, 31));
            d = $urandom;
            f = $urandom;
            if (t < 5) k = 3'(t);
            ref_shift(k, int'(n), d, f, er, ef, ee);
            elat  = (k > 3'd4 || n == 5'd0) ? 1 : int'(n) + 1;
            eruns = (k > 3'd4 || n == 5'd0) ? 0 : int'(n);
            send_req(k, n, d, f);
            n_cmp++; if (got_to !== 1'b0 || got_lat !== elat || got_runs !== eruns || got_badop !== 0) begin
                n_mis++; $display("FAIL rnd%0d_timing: k=%0d n=%0d lat=%0d runs=%0d badop=%0d to=%b, want lat=%0d runs=%0d", t, k, n, got_lat, got_runs, got_badop, got_to, elat, eruns); end
            n_cmp++; if (got_res !== er || got_fo !== ef || got_err !== ee) begin
                n_mis++; $display("FAIL rnd%0d_result: k=%0d n=%0d di=%h fi=%h got res=%h fo=%h err=%b, want %h %h %b", t, k, n, d, f, got_res, got_fo, got_err, er, ef, ee); end
            take_result(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_kind = 3'd1; req_cnt = 5'd8; req_di = 32'hFF00; req_fi = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || alu_op !== 6'h29) begin
            n_mis++; $display("FAIL mid_run: busy=%b op=%h, want 1 29", busy, alu_op); end
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || alu_op !== 6'h00 || alu_di !== 32'h0 || res !== 32'h0 || fo !== 32'h0 || err !== 1'b0) begin
            n_mis++; $display("FAIL reset_abort: ready=%b busy=%b dv=%b op=%h di=%h res=%h fo=%h err=%b", req_ready, busy, done_valid, alu_op, alu_di, res, fo, err); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++; if (done_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_mis++; $display("FAIL no_partial%0d: dv=%b ready=%b, want 0 1", i, done_valid, req_ready); end
        end
    endtask

`ifdef ALU_SEQ_ABORT_EN
    task automatic test_abort();
        logic [31:0] er, ef;
        logic        ee;
        int          guard;
        abort = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (done_valid !== 1'b0 || busy !== 1'b0) begin
            n_mis++; $display("FAIL abort_idle: dv=%b busy=%b, want 0 0", done_valid, busy); end
        abort = 1'b0;
        req_kind = 3'd1; req_cnt = 5'd8; req_di = 32'hF0; req_fi = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!done_valid && guard < 20);
        ref_shift(3'd1, 3, 32'hF0, 32'h0, er, ef, ee);
        n_cmp++; if (guard !== 1 || res !== 32'h1E || fo !== ef || err !== 1'b1) begin
            n_mis++; $display("FAIL abort_run: lat=%0d res=%h fo=%h err=%b, want 1 1e %h 1", guard, res, fo, err, ef); end
        abort = 1'b1;
        @(negedge clk);
        n_cmp++; if (done_valid !== 1'b1 || res !== 32'h1E) begin
            n_mis++; $display("FAIL abort_done: dv=%b res=%h, want 1 1e", done_valid, res); end
        abort = 1'b0;
        take_result(0);
    endtask
`endif

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_kind = 3'd0; req_cnt = 5'd0;
        req_di = 32'h0; req_fi = 32'h0; done_ready = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_directed();
        test_zero_hold();
        test_illegal();
        test_random();
        test_reset_mid();
`ifdef ALU_SEQ_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
